// File: rtl/rx_load_ctrl.sv
// Turns the UART byte stream (WRITE / GO command protocol) into word-wide memory writes
// with a valid/ready handshake, plus go/done/err event pulses.
module rx_load_ctrl #(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [DATA_SIZE-1:0]             byte_in,
  input  logic                             new_byte_in,
  output logic [ADDR_WIDTH-1:0]            wr_addr_out,
  output logic [WORD_BYTES*DATA_SIZE-1:0]  wr_data_out,
  output logic                             wr_valid_out,
  input  logic                             wr_ready_in,
  output logic                             go_out,
  output logic                             done_out,
  output logic                             err_out,
  output logic                             busy_out
);

  localparam int unsigned WordW = WORD_BYTES * DATA_SIZE;
  localparam int unsigned BcW   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW  = 2 * DATA_SIZE;

  typedef enum logic [2:0] {
    StIdle, StAHi, StALo, StCHi, StCLo, StPayload, StFlush
  } state_e;

  state_e                 state_q;
  logic [DATA_SIZE-1:0]   hi_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [CntW-1:0]        cnt_q;
  logic [CntW-1:0]        word_cnt_q;
  logic [BcW-1:0]         byte_cnt_q;
  logic [WordW-1:0]       asm_q;
  logic [ToW-1:0]         idle_cnt_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [WordW-1:0]       wr_data_q;
  logic                   wr_valid_q;
  logic                   go_q, done_q, err_q;

  logic [WordW-1:0]       word_next;
  logic [CntW-1:0]        pair;
  logic [ToW-1:0]         idle_next;
  logic                   word_done;
  logic                   timed_out;
  logic                   can_time_out;

  always_comb begin
    word_next = asm_q;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (byte_cnt_q == BcW'(i)) word_next[i*DATA_SIZE +: DATA_SIZE] = byte_in;
    end
    pair         = {hi_q, byte_in};
    word_done    = (byte_cnt_q == BcW'(WORD_BYTES - 1));
    idle_next    = idle_cnt_q + 1'b1;
    can_time_out = (state_q != StIdle) && (state_q != StFlush);
    timed_out    = can_time_out && !new_byte_in && (idle_next == ToW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      idle_cnt_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      go_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      go_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Accept retires the pending word; a word loaded below in the same cycle overrides this.
      if (wr_valid_q && wr_ready_in) wr_valid_q <= 1'b0;
      if (new_byte_in || !can_time_out) idle_cnt_q <= '0;
      else                              idle_cnt_q <= idle_next;

      if (timed_out) begin
        err_q   <= 1'b1;
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: if (new_byte_in) begin
            if (byte_in == DATA_SIZE'(1))      state_q <= StAHi;
            else if (byte_in == DATA_SIZE'(2)) go_q    <= 1'b1;
            else                               err_q   <= 1'b1;
          end
          StAHi: if (new_byte_in) begin
            hi_q    <= byte_in;
            state_q <= StALo;
          end
          StALo: if (new_byte_in) begin
            addr_q  <= pair[ADDR_WIDTH-1:0];
            state_q <= StCHi;
          end
          StCHi: if (new_byte_in) begin
            hi_q    <= byte_in;
            state_q <= StCLo;
          end
          StCLo: if (new_byte_in) begin
            cnt_q      <= pair;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            if (pair == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              state_q <= StPayload;
            end
          end
          StPayload: if (new_byte_in) begin
            if (!word_done) begin
              asm_q      <= word_next;
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end else if (wr_valid_q && !wr_ready_in) begin
              // Previous word still pending: drop the new one and abort the packet.
              err_q   <= 1'b1;
              state_q <= StIdle;
            end else begin
              wr_data_q  <= word_next;
              wr_addr_q  <= addr_q;
              wr_valid_q <= 1'b1;
              addr_q     <= addr_q + 1'b1;
              word_cnt_q <= word_cnt_q + 1'b1;
              asm_q      <= '0;
              byte_cnt_q <= '0;
              if (CntW'(word_cnt_q + 1'b1) == cnt_q) state_q <= StFlush;
            end
          end
          StFlush: if (!wr_valid_q || wr_ready_in) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;
  assign wr_valid_out = wr_valid_q;
  assign go_out       = go_q;
  assign done_out     = done_q;
  assign err_out      = err_q;
  assign busy_out     = (state_q != StIdle);

endmodule

// File: tb/tb_rx_load_ctrl.sv
// Bench for rx_load_ctrl: table vectors for command decode, directed multi-cycle corner
// cases, and randomized packets checked against a packet-level write model.
module tb_rx_load_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned WB = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_i;
  logic        new_b;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready, go, done, err, busy;

  always #5 clk = ~clk;

  rx_load_ctrl #(
    .DATA_SIZE     (DW),
    .WORD_BYTES    (WB),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .byte_in     (byte_i),
    .new_byte_in (new_b),
    .wr_addr_out (wr_addr),
    .wr_data_out (wr_data),
    .wr_valid_out(wr_valid),
    .wr_ready_in (wr_ready),
    .go_out      (go),
    .done_out    (done),
    .err_out     (err),
    .busy_out    (busy)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] b;
    logic       go, err, done, busy;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   go_n = 0, err_n = 0, done_n = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  wr_t  obs_q[$];
  wr_t  exp_q[$];
  logic [7:0] pay[$];
  logic pv = 1'b0;
  wr_t  pw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rdy_rand) wr_ready = ($urandom_range(0, 2) == 0) || (cyc % 4 == 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_i = b;
    new_b  = 1'b1;
    tick();
    new_b  = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic [31:0] pack_word(input int w);
    logic [31:0] d = '0;
    for (int j = 0; j < WB; j++) d = d | (32'(pay[w*WB+j]) << (8 * j));
    return d;
  endfunction

  task automatic fill_pay(input int nbytes);
    pay.delete();
    for (int i = 0; i < nbytes; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends a full WRITE packet from pay[] and records the words the memory should see.
  task automatic write_pkt(input logic [15:0] a, input logic [15:0] n, input int gap);
    send_byte(8'h01, gap);
    send_byte(a[15:8], gap);
    send_byte(a[7:0], gap);
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    for (int i = 0; i < int'(n) * WB; i++) send_byte(pay[i], gap);
    for (int w = 0; w < int'(n); w++) exp_q.push_back({a + 16'(w), pack_word(w)});
  endtask

  task automatic cmp_writes(input string name);
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      wr_t o = obs_q.pop_front();
      wr_t e = exp_q.pop_front();
      check({name, "_write"}, 64'(o), 64'(e));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Monitor: event counts, accepted writes, and hold stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv <= 1'b0;
    end else begin
      if (go)   go_n   <= go_n + 1;
      if (err)  err_n  <= err_n + 1;
      if (done) done_n <= done_n + 1;
      if (pv) check("hold_stable", {15'd0, wr_valid, wr_addr, wr_data}, {15'd0, 1'b1, pw});
      pv <= wr_valid && !wr_ready;
      pw <= {wr_addr, wr_data};
      if (wr_valid && wr_ready) obs_q.push_back({wr_addr, wr_data});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int   g0, e0, d0, ge, ee, de;
    bit   early, seen;

    tbl[0] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h34, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; byte_i = '0; new_b = 1'b0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {15'd0, wr_valid, go, done, err, busy, wr_addr, wr_data}, 64'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Command decode table: outputs one cycle after the strobe, pulses gone the cycle after.
    for (int i = 0; i < 9; i++) begin
      byte_i = tbl[i].b;
      new_b  = 1'b1;
      tick();
      new_b  = 1'b0;
      @(negedge clk);
      check($sformatf("tbl%0d_pulse", i), {go, err, done, busy},
            {tbl[i].go, tbl[i].err, tbl[i].done, tbl[i].busy});
      tick();
      @(negedge clk);
      check($sformatf("tbl%0d_after", i), {go, err, done, busy}, {3'b000, tbl[i].busy});
    end
    tick();

    // Basic write with ready held high.
    wr_ready = 1'b1;
    pay.delete();
    for (int i = 1; i <= 8; i++) pay.push_back(8'(i));
    d0 = done_n;
    write_pkt(16'h0010, 16'd2, 1);
    repeat (6) tick();
    @(negedge clk);
    check("basic_word0_model", {exp_q[0].addr, exp_q[0].data}, {16'h0010, 32'h04030201});
    check("basic_word1_model", {exp_q[1].addr, exp_q[1].data}, {16'h0011, 32'h08070605});
    cmp_writes("basic");
    check("basic_done", 64'(done_n - d0), 64'd1);
    check("basic_busy", busy, 1'b0);

    // Address wrap.
    fill_pay(8);
    write_pkt(16'hFFFF, 16'd2, 1);
    repeat (6) tick();
    @(negedge clk);
    check("wrap_addr_model", {exp_q[0].addr, exp_q[1].addr}, {16'hFFFF, 16'h0000});
    cmp_writes("wrap");

    // Overflow: ready low across two completed words.
    wr_ready = 1'b0;
    fill_pay(8);
    e0 = err_n; d0 = done_n;
    send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h20, 1);
    send_byte(8'h00, 1); send_byte(8'h03, 1);
    for (int i = 0; i < 8; i++) send_byte(pay[i], 1);
    tick();
    @(negedge clk);
    check("ovf_err", 64'(err_n - e0), 64'd1);
    check("ovf_busy", busy, 1'b0);
    check("ovf_pending", {wr_valid, wr_addr, wr_data}, {1'b1, 16'h0020, pack_word(0)});
    exp_q.push_back({16'h0020, pack_word(0)});
    wr_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    cmp_writes("ovf");
    check("ovf_no_done", 64'(done_n - d0), 64'd0);
    check("ovf_valid_drop", wr_valid, 1'b0);

    // Timeout mid-payload after two bytes.
    e0 = err_n;
    send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h40, 1);
    send_byte(8'h00, 1); send_byte(8'h01, 1);
    send_byte(8'hAA, 1);
    byte_i = 8'hBB; new_b = 1'b1;
    tick();
    new_b = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= int'(TO) - 2; k++) begin
      @(negedge clk);
      if (err) early = 1'b1;
    end
    check("timeout_not_early", early, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (err) seen = 1'b1;
    end
    check("timeout_err", seen, 1'b1);
    check("timeout_err_count", 64'(err_n - e0), 64'd1);
    check("timeout_busy", busy, 1'b0);
    cmp_writes("timeout_nowrite");
    fill_pay(4);
    d0 = done_n;
    write_pkt(16'h0050, 16'd1, 1);
    repeat (6) tick();
    @(negedge clk);
    cmp_writes("after_timeout");
    check("after_timeout_done", 64'(done_n - d0), 64'd1);

    // Asynchronous reset with a write pending.
    wr_ready = 1'b0;
    fill_pay(8);
    send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h60, 1);
    send_byte(8'h00, 1); send_byte(8'h02, 1);
    for (int i = 0; i < 4; i++) send_byte(pay[i], 1);
    @(negedge clk);
    check("rst_pre_valid", wr_valid, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_async", {15'd0, wr_valid, go, done, err, busy, wr_addr, wr_data}, 64'd0);
    tick();
    rst_n = 1'b1;
    wr_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_idle", {busy, wr_valid}, 2'b00);
    cmp_writes("rst_drop");
    g0 = go_n;
    send_byte(8'h02, 2);
    @(negedge clk);
    check("rst_then_go", 64'(go_n - g0), 64'd1);

    // Randomized packets against the packet-level model.
    rdy_rand = 1'b1;
    g0 = go_n; e0 = err_n; d0 = done_n;
    ge = 0; ee = 0; de = 0;
    for (int p = 0; p < 40; p++) begin
      int k = int'($urandom_range(0, 9));
      if (k < 2) begin
        send_byte(8'h02, int'($urandom_range(1, 3)));
        ge++;
      end else if (k == 2) begin
        send_byte(8'($urandom_range(3, 255)), int'($urandom_range(1, 3)));
        ee++;
      end else begin
        logic [15:0] n = 16'($urandom_range(0, 3));
        logic [15:0] a = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
        fill_pay(int'(n) * WB);
        write_pkt(a, n, int'($urandom_range(1, 3)));
        de++;
        repeat (10) tick();
      end
    end
    repeat (10) tick();
    @(negedge clk);
    rdy_rand = 1'b0;
    tick();
    @(negedge clk);
    cmp_writes("random");
    check("random_go", 64'(go_n - g0), 64'(ge));
    check("random_err", 64'(err_n - e0), 64'(ee));
    check("random_done", 64'(done_n - d0), 64'(de));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
